// File: rtl/reset_release_voter.sv
// rtl/reset_release_voter.sv - synchronizes, majority-votes and stretches triplicated reset requests
module reset_release_voter #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rstA,
   input  logic             rstB,
   input  logic             rstC,
   input  logic [2:0]       porStatus,
   input  logic             clearErr,
   output logic             rstOut,
   output logic             ready,
   output logic             mismatch,
   output logic [2:0]       errChannel,
   output logic [CNT_W-1:0] errCount,
   output logic [1:0]       state
);

   localparam int               HCW       = $clog2(HOLD_CYCLES + 1);
   localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_ASSERTED = 2'b00,
      ST_HOLD     = 2'b01,
      ST_RUN      = 2'b10
   } state_t;

   // Bit layout of one synchronizer stage: {por[2:0], C, B, A}
   logic [SYNC_STAGES-1:0][5:0] r_sync;
   logic [5:0]                  w_sync_in;
   logic [5:0]                  w_s;
   logic                        w_rst_vote;
   logic                        w_por_vote;
   logic                        w_req;
   logic [2:0]                  w_dis;
   logic                        w_any_dis;

   state_t                      r_state;
   state_t                      w_next_state;
   logic [HCW-1:0]              r_hold_cnt;
   logic [HCW-1:0]              w_next_hold_cnt;
   logic                        r_rst_out;

   logic                        r_mismatch;
   logic [2:0]                  r_err_channel;
   logic [CNT_W-1:0]            r_err_count;

   assign w_sync_in = {porStatus, rstC, rstB, rstA};

   // Synchronizer chain; loads all ones on rst so the block leaves rst requesting reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '1;
      end else begin
         r_sync[0] <= w_sync_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_s        = r_sync[SYNC_STAGES-1];
   assign w_rst_vote = (w_s[0] & w_s[1]) | (w_s[0] & w_s[2]) | (w_s[1] & w_s[2]);
   assign w_por_vote = (w_s[3] & w_s[4]) | (w_s[3] & w_s[5]) | (w_s[4] & w_s[5]);
   assign w_req      = w_rst_vote | w_por_vote;

   // A channel disagrees if either its reset replica or its POR bit differs from the vote
   assign w_dis     = ({3{w_rst_vote}} ^ w_s[2:0]) | ({3{w_por_vote}} ^ w_s[5:3]);
   assign w_any_dis = |w_dis;

   // Next-state logic: any request restarts the full hold period
   always_comb begin
      w_next_state    = r_state;
      w_next_hold_cnt = r_hold_cnt;
      case (r_state)
         ST_ASSERTED: begin
            if (!w_req) begin
               w_next_state    = ST_HOLD;
               w_next_hold_cnt = '0;
            end
         end
         ST_HOLD: begin
            if (w_req) begin
               w_next_state = ST_ASSERTED;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_next_state = ST_RUN;
            end else begin
               w_next_hold_cnt = r_hold_cnt + HCW'(1);
            end
         end
         ST_RUN: begin
            if (w_req) begin
               w_next_state = ST_ASSERTED;
            end
         end
         default: begin
            w_next_state = ST_ASSERTED;
         end
      endcase
   end

   // State register; rstOut is derived from the next state so it moves on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_ASSERTED;
         r_hold_cnt <= '0;
         r_rst_out  <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_hold_cnt <= w_next_hold_cnt;
         r_rst_out  <= (w_next_state != ST_RUN);
      end
   end

   // Disagreement reporting; clear wins over a same-cycle mismatch and that cycle is not counted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mismatch    <= 1'b0;
         r_err_channel <= '0;
         r_err_count   <= '0;
      end else begin
         r_mismatch <= w_any_dis;
         if (clearErr) begin
            r_err_channel <= '0;
            r_err_count   <= '0;
         end else if (w_any_dis) begin
            r_err_channel <= r_err_channel | w_dis;
            if (r_err_count != CNT_MAX) begin
               r_err_count <= r_err_count + CNT_W'(1);
            end
         end
      end
   end

   assign rstOut     = r_rst_out;
   assign ready      = !r_rst_out;
   assign mismatch   = r_mismatch;
   assign errChannel = r_err_channel;
   assign errCount   = r_err_count;
   assign state      = r_state;

endmodule
